// File: rtl/display_scan_pwm_pkg.sv
// ----------------------------------------------------------------------------
// display_pkg
// Shared constants for the 4-digit multiplexed seven-segment scanner.
//   - SEG_0..SEG_9, SEG_DASH, SEG_BLANK : active-low cathode codes {dp,g..a}
//   - NUM_DIGITS                        : number of multiplexed digits
//   - digit_idx_t                       : digit-slot index type
// ----------------------------------------------------------------------------
package display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    // Bit 7 is the decimal point; every code here leaves it off (high).
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/display_scan_pwm_if.sv
// ----------------------------------------------------------------------------
// display_scan_pwm_if
// Groups the clock-display inputs and the LED pin outputs.
//   Digit3..Digit0  : BCD digits (hours tens .. minutes units)
//   Load            : level; while high the digits are captured every cycle
//   Brightness      : PWM duty, 0 = off, 1..14 = n/16, 15 = always on
//   SegmentDrivers  : active-low anode enables, bit i = digit i
//   SevenSegment    : active-low cathodes {dp,g,f,e,d,c,b,a}
//   FrameDone       : one-cycle pulse after the digit-3 slot ends
// master = the side that supplies digits (e.g. clock core, testbench)
// slave  = the scanner
// ----------------------------------------------------------------------------
interface display_scan_pwm_if;

    logic [3:0] Digit3;
    logic [3:0] Digit2;
    logic [3:0] Digit1;
    logic [3:0] Digit0;
    logic       Load;
    logic [3:0] Brightness;
    logic [3:0] SegmentDrivers;
    logic [7:0] SevenSegment;
    logic       FrameDone;

    modport master (
        output Digit3, Digit2, Digit1, Digit0, Load, Brightness,
        input  SegmentDrivers, SevenSegment, FrameDone
    );

    modport slave (
        input  Digit3, Digit2, Digit1, Digit0, Load, Brightness,
        output SegmentDrivers, SevenSegment, FrameDone
    );

endinterface

// File: rtl/display_scan_pwm_seg_decode.sv
// ----------------------------------------------------------------------------
// seg_decode
// Combinational BCD to active-low seven-segment decoder (no dp).
//   bcd : 4-bit digit value; 10..15 render as a dash
//   seg : {g,f,e,d,c,b,a}, active low
// ----------------------------------------------------------------------------
module seg_decode
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH[6:0];
        case (bcd)
            4'd0:    seg = SEG_0[6:0];
            4'd1:    seg = SEG_1[6:0];
            4'd2:    seg = SEG_2[6:0];
            4'd3:    seg = SEG_3[6:0];
            4'd4:    seg = SEG_4[6:0];
            4'd5:    seg = SEG_5[6:0];
            4'd6:    seg = SEG_6[6:0];
            4'd7:    seg = SEG_7[6:0];
            4'd8:    seg = SEG_8[6:0];
            4'd9:    seg = SEG_9[6:0];
            default: seg = SEG_DASH[6:0];
        endcase
    end

endmodule

// File: rtl/display_scan_pwm.sv
// ----------------------------------------------------------------------------
// display_scan_pwm
// Time-multiplexed 4-digit seven-segment driver with PWM brightness and an
// anti-ghosting dark interval at the start of every digit slot.
//
// Ports:
//   CLK100MHZ : sole clock, rising edge
//   Reset     : synchronous, active low
//   bus       : display_scan_pwm_if.slave (digits, Load, Brightness in;
//               SegmentDrivers, SevenSegment, FrameDone out)
//
// Parameters:
//   SCAN_DIV        : clocks per digit slot (64 .. 2**20)
//   BLANK_CYCLES    : dark cycles at the start of each slot (< SCAN_DIV)
//   HALF_SEC_FRAMES : frames per colon toggle
//
// Build option:
//   COLON_BLINK_EN  : when defined, the colon (digit-2 dp) blinks, toggling
//                     every HALF_SEC_FRAMES frames; otherwise it stays lit.
// ----------------------------------------------------------------------------
module display_scan_pwm
    import display_pkg::*;
#(
    parameter int SCAN_DIV        = 100000,
    parameter int BLANK_CYCLES    = 16,
    parameter int HALF_SEC_FRAMES = 125
) (
    input  logic               CLK100MHZ,
    input  logic               Reset,
    display_scan_pwm_if.slave  bus
);

    localparam int                CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYCLES);

    if (SCAN_DIV < 64 || SCAN_DIV > (1 << 20)) begin : g_bad_scan_div
        $error("SCAN_DIV out of range 64..2**20");
    end
    if (BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank
        $error("BLANK_CYCLES must be smaller than SCAN_DIV");
    end
    if (HALF_SEC_FRAMES < 1) begin : g_bad_half
        $error("HALF_SEC_FRAMES must be at least 1");
    end

    logic [CNT_W-1:0]                slot_cnt;
    digit_idx_t                      idx;
    logic [3:0]                      pwm_cnt;
    logic [NUM_DIGITS-1:0][3:0]      shadow;
    logic                            colon_on;

    logic                            slot_end;
    logic                            lit;
    logic [3:0]                      bcd_sel;
    logic [6:0]                      seg7;
    logic                            dp_nxt;
    logic [3:0]                      an_nxt;

    logic [3:0]                      an_p1;
    logic [7:0]                      seg_p1;
    logic                            fd_p1;

    // ---- stage 0: scan state -> combinational anode/cathode selection ----
    assign slot_end = (slot_cnt == SLOT_LAST);
    assign bcd_sel  = shadow[idx];

    // Anode is dark during the blank interval, then gated by the PWM compare.
    assign lit = (slot_cnt >= BLANK_END) &&
                 ((bus.Brightness == 4'hF) || (pwm_cnt < bus.Brightness));

    always_comb begin
        an_nxt = 4'hF;
        if (lit) begin
            an_nxt[idx] = 1'b0;
        end
    end

    // Only digit 2 carries the colon on its decimal point.
    assign dp_nxt = (idx == 2'd2) ? ~colon_on : 1'b1;

    seg_decode u_seg_decode (
        .bcd (bcd_sel),
        .seg (seg7)
    );

    // ---- stage 1: registered pins and scan-state update ----
    always_ff @(posedge CLK100MHZ) begin
        if (!Reset) begin
            slot_cnt <= '0;
            idx      <= '0;
            pwm_cnt  <= '0;
            shadow   <= '0;
            an_p1    <= 4'hF;
            seg_p1   <= SEG_BLANK;
            fd_p1    <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (slot_end) begin
                slot_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
            if (bus.Load) begin
                shadow <= {bus.Digit3, bus.Digit2, bus.Digit1, bus.Digit0};
            end
            an_p1  <= an_nxt;
            seg_p1 <= {dp_nxt, seg7};
            fd_p1  <= slot_end && (idx == 2'd3);
        end
    end

`ifdef COLON_BLINK_EN
    localparam int FR_W = (HALF_SEC_FRAMES > 1) ? $clog2(HALF_SEC_FRAMES) : 1;

    logic [FR_W-1:0] frame_cnt;

    // Counts completed frames using the registered FrameDone pulse.
    always_ff @(posedge CLK100MHZ) begin
        if (!Reset) begin
            frame_cnt <= '0;
            colon_on  <= 1'b1;
        end else if (fd_p1) begin
            if (frame_cnt == FR_W'(HALF_SEC_FRAMES - 1)) begin
                frame_cnt <= '0;
                colon_on  <= ~colon_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    assign colon_on = 1'b1;
`endif

    assign bus.SegmentDrivers = an_p1;
    assign bus.SevenSegment   = seg_p1;
    assign bus.FrameDone      = fd_p1;

endmodule

// File: tb/tb_display_scan_pwm.sv
// ----------------------------------------------------------------------------
// tb_display_scan_pwm
// Self-checking bench for display_scan_pwm (SCAN_DIV=64, BLANK_CYCLES=4,
// HALF_SEC_FRAMES=3). A cycle model predicts the pin values each edge and
// queues them; each scenario task pops and compares, plus checks a few
// scenario-specific properties directly.
// ----------------------------------------------------------------------------
module tb_display_scan_pwm;

    localparam int SCAN_DIV        = 64;
    localparam int BLANK_CYCLES    = 4;
    localparam int HALF_SEC_FRAMES = 3;
    localparam int FRAME           = 4 * SCAN_DIV;

    logic CLK100MHZ = 1'b0;
    logic Reset     = 1'b0;

    display_scan_pwm_if bus ();

    display_scan_pwm #(
        .SCAN_DIV        (SCAN_DIV),
        .BLANK_CYCLES    (BLANK_CYCLES),
        .HALF_SEC_FRAMES (HALF_SEC_FRAMES)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state (value before the next clock edge)
    int         m_slot  = 0;
    int         m_idx   = 0;
    int         m_pwm   = 0;
    int         m_frame = 0;
    bit         m_phase = 1'b1;
    logic       m_fd    = 1'b0;
    logic [3:0] m_sh [4];

    function automatic logic [7:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    // One clock: predict the pins produced by this edge, queue them, advance
    // the model, then settle 1 time unit past the edge.
    task automatic tick();
        exp_t e;
        logic lit;
        @(posedge CLK100MHZ);
        if (!Reset) begin
            e       = '{an: 4'hF, seg: 8'hFF, fd: 1'b0};
            m_slot  = 0;
            m_idx   = 0;
            m_pwm   = 0;
            m_frame = 0;
            m_phase = 1'b1;
            m_fd    = 1'b0;
            for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
        end else begin
            lit = (m_slot >= BLANK_CYCLES) &&
                  ((bus.Brightness == 4'd15) || (m_pwm < int'(bus.Brightness)));
            e.an = 4'hF;
            if (lit) e.an[m_idx] = 1'b0;
            e.seg    = ref_seg(m_sh[m_idx]);
            e.seg[7] = (m_idx == 2) ? !m_phase : 1'b1;
            e.fd     = (m_slot == SCAN_DIV - 1) && (m_idx == 3);
`ifdef COLON_BLINK_EN
            if (m_fd) begin
                if (m_frame == HALF_SEC_FRAMES - 1) begin
                    m_frame = 0;
                    m_phase = !m_phase;
                end else begin
                    m_frame++;
                end
            end
`endif
            m_fd  = e.fd;
            m_pwm = (m_pwm + 1) % 16;
            if (m_slot == SCAN_DIV - 1) begin
                m_slot = 0;
                m_idx  = (m_idx + 1) % 4;
            end else begin
                m_slot++;
            end
            if (bus.Load) begin
                m_sh[0] = bus.Digit0;
                m_sh[1] = bus.Digit1;
                m_sh[2] = bus.Digit2;
                m_sh[3] = bus.Digit3;
            end
        end
        sb.push_back(e);
        #1;
    endtask

    task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
        bus.Digit3 = d3;
        bus.Digit2 = d2;
        bus.Digit1 = d1;
        bus.Digit0 = d0;
    endtask

    // Two reset cycles; their queued predictions are discarded.
    task automatic do_reset();
        Reset    = 1'b0;
        bus.Load = 1'b0;
        tick();
        tick();
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        Reset          = 1'b0;
        bus.Load       = 1'b0;
        bus.Brightness = 4'd15;
        set_digits(4'd9, 4'd9, 4'd9, 4'd9);
        repeat (3) begin
            tick();
            e = sb.pop_front();
            n_cmp++; if (bus.SegmentDrivers !== 4'hF) begin n_err++; $display("FAIL reset_an got %h want f", bus.SegmentDrivers); end
            n_cmp++; if (bus.SevenSegment !== 8'hFF) begin n_err++; $display("FAIL reset_seg got %h want ff", bus.SevenSegment); end
            n_cmp++; if (bus.FrameDone !== 1'b0) begin n_err++; $display("FAIL reset_fd got %b want 0", bus.FrameDone); end
        end
        // Shadows cleared: digit 0 shows '0' once the blank interval ends.
        Reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e = sb.pop_front();
            n_cmp++; if (bus.SegmentDrivers !== e.an) begin n_err++; $display("FAIL reset_rel_an k=%0d got %h want %h", k, bus.SegmentDrivers, e.an); end
            n_cmp++; if (bus.SevenSegment !== e.seg) begin n_err++; $display("FAIL reset_rel_seg k=%0d got %h want %h", k, bus.SevenSegment, e.seg); end
            if (k >= 5) begin
                n_cmp++; if (bus.SegmentDrivers !== 4'hE || bus.SevenSegment !== 8'hC0) begin
                    n_err++; $display("FAIL reset_shadow k=%0d got %h/%h want e/c0", k, bus.SegmentDrivers, bus.SevenSegment);
                end
            end
        end
    endtask

    task automatic test_scan();
        exp_t e;
        int   cnt_e, cnt_d, cnt_b, cnt_7, cnt_other, n_fd, fd_at1, fd_at2;
        logic [7:0] want;
        cnt_e = 0; cnt_d = 0; cnt_b = 0; cnt_7 = 0; cnt_other = 0;
        n_fd = 0; fd_at1 = -1; fd_at2 = -1;
        do_reset();
        bus.Brightness = 4'd15;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        bus.Load = 1'b1;
        Reset    = 1'b1;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            tick();
            if (k == 1) bus.Load = 1'b0;
            e = sb.pop_front();
            n_cmp++; if (bus.SegmentDrivers !== e.an) begin n_err++; $display("FAIL scan_an k=%0d got %h want %h", k, bus.SegmentDrivers, e.an); end
            n_cmp++; if (bus.SevenSegment !== e.seg) begin n_err++; $display("FAIL scan_seg k=%0d got %h want %h", k, bus.SevenSegment, e.seg); end
            n_cmp++; if (bus.FrameDone !== e.fd) begin n_err++; $display("FAIL scan_fd k=%0d got %b want %b", k, bus.FrameDone, e.fd); end
            want = 8'hxx;
            case (bus.SegmentDrivers)
                4'hE: begin cnt_e++; want = 8'h99; end
                4'hD: begin cnt_d++; want = 8'hB0; end
                4'hB: begin cnt_b++; want = 8'h24; end
                4'h7: begin cnt_7++; want = 8'hF9; end
                4'hF: ;
                default: cnt_other++;
            endcase
            if (bus.SegmentDrivers != 4'hF) begin
                n_cmp++; if (bus.SevenSegment !== want) begin n_err++; $display("FAIL scan_digit_code k=%0d an=%h got %h want %h", k, bus.SegmentDrivers, bus.SevenSegment, want); end
            end
            if (bus.FrameDone === 1'b1) begin
                n_fd++;
                if (fd_at1 < 0) fd_at1 = k; else fd_at2 = k;
            end
        end
        n_cmp++; if (cnt_e != 120 || cnt_d != 120 || cnt_b != 120 || cnt_7 != 120 || cnt_other != 0) begin
            n_err++; $display("FAIL scan_lit_counts got %0d/%0d/%0d/%0d/%0d want 120 each, 0 other", cnt_e, cnt_d, cnt_b, cnt_7, cnt_other);
        end
        n_cmp++; if (n_fd != 2 || fd_at1 != FRAME || fd_at2 != 2 * FRAME) begin
            n_err++; $display("FAIL scan_framedone got n=%0d at %0d,%0d want 2 at %0d,%0d", n_fd, fd_at1, fd_at2, FRAME, 2 * FRAME);
        end
    endtask

    task automatic test_pwm();
        exp_t e;
        int   lit4, lit0;
        lit4 = 0; lit0 = 0;
        do_reset();
        set_digits(4'd5, 4'd6, 4'd7, 4'd8);
        bus.Brightness = 4'd4;
        Reset = 1'b1;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            tick();
            if (k == FRAME) bus.Brightness = 4'd0;
            e = sb.pop_front();
            n_cmp++; if (bus.SegmentDrivers !== e.an) begin n_err++; $display("FAIL pwm_an k=%0d got %h want %h", k, bus.SegmentDrivers, e.an); end
            n_cmp++; if (bus.SevenSegment !== e.seg) begin n_err++; $display("FAIL pwm_seg k=%0d got %h want %h", k, bus.SevenSegment, e.seg); end
            if (bus.SegmentDrivers != 4'hF) begin
                if (k <= FRAME) lit4++; else lit0++;
            end
        end
        // Per slot: counts 4..63, lit where count mod 16 < 4 -> 12 cycles.
        n_cmp++; if (lit4 != 48) begin n_err++; $display("FAIL pwm_duty4 got %0d want 48", lit4); end
        n_cmp++; if (lit0 != 0) begin n_err++; $display("FAIL pwm_duty0 got %0d want 0", lit0); end
    endtask

    task automatic test_decode_hold();
        exp_t e;
        int   n_on, n_bad;
        n_on = 0; n_bad = 0;
        do_reset();
        bus.Brightness = 4'd15;
        set_digits(4'd0, 4'd0, 4'd0, 4'd12);
        bus.Load = 1'b1;
        Reset    = 1'b1;
        for (int k = 1; k <= FRAME + SCAN_DIV; k++) begin
            tick();
            if (k == 1) begin
                bus.Load   = 1'b0;
                bus.Digit0 = 4'd7;
            end
            e = sb.pop_front();
            n_cmp++; if (bus.SegmentDrivers !== e.an) begin n_err++; $display("FAIL hold_an k=%0d got %h want %h", k, bus.SegmentDrivers, e.an); end
            n_cmp++; if (bus.SevenSegment !== e.seg) begin n_err++; $display("FAIL hold_seg k=%0d got %h want %h", k, bus.SevenSegment, e.seg); end
            if (bus.SegmentDrivers == 4'hE) begin
                n_on++;
                if (bus.SevenSegment !== 8'hBF) n_bad++;
            end
        end
        n_cmp++; if (n_on != 120 || n_bad != 0) begin n_err++; $display("FAIL hold_dash got on=%0d bad=%0d want 120/0", n_on, n_bad); end
    endtask

    task automatic test_load_terminal();
        exp_t e;
        int   guard;
        do_reset();
        bus.Brightness = 4'd15;
        set_digits(4'd0, 4'd0, 4'd3, 4'd0);
        bus.Load = 1'b1;
        Reset    = 1'b1;
        tick();
        void'(sb.pop_front());
        bus.Load = 1'b0;
        guard = 0;
        while (!(m_slot == SCAN_DIV - 1 && m_idx == 0) && guard < 300) begin
            tick();
            e = sb.pop_front();
            n_cmp++; if (bus.SevenSegment !== e.seg) begin n_err++; $display("FAIL lt_pre_seg got %h want %h", bus.SevenSegment, e.seg); end
            guard++;
        end
        n_cmp++; if (guard >= 300) begin n_err++; $display("FAIL lt_timeout got %0d cycles want < 300", guard); end
        // Load lands on the terminal-count cycle of the digit-0 slot.
        bus.Digit1 = 4'd8;
        bus.Load   = 1'b1;
        tick();
        bus.Load = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (bus.SevenSegment !== e.seg) begin n_err++; $display("FAIL lt_edge_seg got %h want %h", bus.SevenSegment, e.seg); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            e = sb.pop_front();
            n_cmp++; if (bus.SegmentDrivers !== e.an) begin n_err++; $display("FAIL lt_an k=%0d got %h want %h", k, bus.SegmentDrivers, e.an); end
            n_cmp++; if (bus.SevenSegment !== 8'h80) begin n_err++; $display("FAIL lt_first_digit1 k=%0d got %h want 80", k, bus.SevenSegment); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        bus.Brightness = 4'd15;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        bus.Load = 1'b1;
        Reset    = 1'b1;
        for (int k = 1; k <= SCAN_DIV + 30; k++) begin
            tick();
            bus.Load = 1'b0;
            e = sb.pop_front();
            n_cmp++; if (bus.SegmentDrivers !== e.an) begin n_err++; $display("FAIL mid_pre_an k=%0d got %h want %h", k, bus.SegmentDrivers, e.an); end
        end
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        e = sb.pop_front();
        n_cmp++; if (bus.SegmentDrivers !== 4'hF) begin n_err++; $display("FAIL mid_rst_an got %h want f", bus.SegmentDrivers); end
        n_cmp++; if (bus.SevenSegment !== 8'hFF) begin n_err++; $display("FAIL mid_rst_seg got %h want ff", bus.SevenSegment); end
        n_cmp++; if (bus.FrameDone !== 1'b0) begin n_err++; $display("FAIL mid_rst_fd got %b want 0", bus.FrameDone); end
        for (int k = 1; k <= 70; k++) begin
            tick();
            e = sb.pop_front();
            n_cmp++; if (bus.SegmentDrivers !== e.an) begin n_err++; $display("FAIL mid_post_an k=%0d got %h want %h", k, bus.SegmentDrivers, e.an); end
            n_cmp++; if (bus.SevenSegment !== e.seg) begin n_err++; $display("FAIL mid_post_seg k=%0d got %h want %h", k, bus.SevenSegment, e.seg); end
            if (k <= BLANK_CYCLES) begin
                n_cmp++; if (bus.SegmentDrivers !== 4'hF) begin n_err++; $display("FAIL mid_blank k=%0d got %h want f", k, bus.SegmentDrivers); end
            end else if (k <= SCAN_DIV) begin
                n_cmp++; if (bus.SegmentDrivers !== 4'hE || bus.SevenSegment !== 8'hC0) begin
                    n_err++; $display("FAIL mid_digit0 k=%0d got %h/%h want e/c0", k, bus.SegmentDrivers, bus.SevenSegment);
                end
            end
        end
    endtask

    task automatic test_colon();
        exp_t e;
        int   frame;
        logic want_dp;
        do_reset();
        bus.Brightness = 4'd15;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        bus.Load = 1'b1;
        Reset    = 1'b1;
        for (int k = 1; k <= 7 * FRAME; k++) begin
            tick();
            bus.Load = 1'b0;
            e = sb.pop_front();
            n_cmp++; if (bus.SevenSegment !== e.seg) begin n_err++; $display("FAIL colon_seg k=%0d got %h want %h", k, bus.SevenSegment, e.seg); end
            n_cmp++; if (bus.FrameDone !== e.fd) begin n_err++; $display("FAIL colon_fd k=%0d got %b want %b", k, bus.FrameDone, e.fd); end
            if (bus.SegmentDrivers == 4'hB) begin
                frame = (k - 1) / FRAME;
`ifdef COLON_BLINK_EN
                want_dp = ((frame % 6) < 3) ? 1'b0 : 1'b1;
`else
                want_dp = 1'b0;
`endif
                n_cmp++; if (bus.SevenSegment[7] !== want_dp) begin
                    n_err++; $display("FAIL colon_dp frame=%0d got %b want %b", frame, bus.SevenSegment[7], want_dp);
                end
            end
        end
    endtask

    initial begin
        bus.Load       = 1'b0;
        bus.Brightness = 4'd0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
        test_reset();
        test_scan();
        test_pwm();
        test_decode_hold();
        test_load_terminal();
        test_reset_mid();
        test_colon();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
